sm_uart_rx: RTL and testbench

- UART receiver (8N1, LSB first) on the board's RsRx pin. Sits directly upstream of the CPU core on the Nexys4 top.
- Turns the serial stream into single-cycle byte strobes.
- Packs every four bytes little-endian into a 32-bit word, offered on a valid/ready handshake. The consumer is the program loader or a memory-mapped receive register.
- Runs on the board clock, not the divided CPU clock.

---
 rtl/sm_uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_sm_uart_rx.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_uart_rx.sv
// sm_uart_rx: 8N1 UART receiver with 16x oversampling. It emits a one-cycle
// strobe for each received byte and packs every four bytes little-endian into
// a 32-bit word that is offered on a valid/ready handshake.
module sm_uart_rx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        overrun,
  input  logic        clr_err,
  output logic        busy
);

  // Clocks per 16x oversample tick; must be at least 2.
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  state_t        state_q;
  logic [3:0]    os_q;
  logic [2:0]    bi_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_data_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  logic [1:0]    cnt_q;
  logic [31:0]   asm_q;
  logic [31:0]   word_data_q;
  logic          word_valid_q;
  logic          overrun_q;

  logic          complete;
  logic          accept;
  logic [31:0]   word_d;

  // Two-flop synchronizer; the line idles high so both stages reset to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  // Free-running oversample tick divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Receive FSM: qualify start bit at mid-bit, then sample every 16 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      os_q         <= '0;
      bi_q         <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            os_q    <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (os_q == 4'd7) begin
              // A line that is high again at mid start bit was a glitch.
              if (rx_s_q) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_DATA;
                os_q    <= '0;
                bi_q    <= '0;
              end
            end else begin
              os_q <= os_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            // os wraps 15 -> 0, which also leaves it at 0 for the stop bit.
            os_q <= os_q + 4'd1;
            if (os_q == 4'd15) begin
              shift_q[bi_q] <= rx_s_q;
              bi_q          <= bi_q + 3'd1;
              if (bi_q == 3'd7) begin
                state_q <= S_STOP;
              end
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            os_q <= os_q + 4'd1;
            if (os_q == 4'd15) begin
              if (rx_s_q) begin
                byte_data_q  <= shift_q;
                byte_valid_q <= 1'b1;
                state_q      <= S_IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_BREAK;
              end
            end
          end
        end
        S_BREAK: begin
          // Hold here until the line recovers so a long break flags only once.
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign complete = byte_valid_q && (cnt_q == 2'd3);
  assign accept   = word_valid_q && word_ready;

  // Completed word: lanes 0..2 from the assembly register, lane 3 is the new byte.
  always_comb begin
    word_d        = asm_q;
    word_d[31:24] = byte_data_q;
  end

  // Lane assembly; a framing error throws away the partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (frame_err_q) begin
      cnt_q <= '0;
    end else if (byte_valid_q) begin
      asm_q[{cnt_q, 3'b000} +: 8] <= byte_data_q;
      cnt_q                       <= cnt_q + 2'd1;
    end
  end

  // Output word register and handshake; a full slot drops the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
    end else if (complete && (!word_valid_q || accept)) begin
      word_data_q  <= word_d;
      word_valid_q <= 1'b1;
    end else if (accept) begin
      word_valid_q <= 1'b0;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (complete && word_valid_q && !accept) begin
      overrun_q <= 1'b1;
    end else if (clr_err) begin
      overrun_q <= 1'b0;
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm_uart_rx.sv
// Bench for sm_uart_rx: serial frames driven at 160 clk/bit, a byte/word
// reference model updated on the falling edge, plus directed literal checks.
module tb_sm_uart_rx;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLKS = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        word_ready = 1'b1;
  logic        clr_err = 1'b0;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  sm_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected traffic, pushed by the frame driver.
  logic [7:0]  exp_bytes[$];
  int          pend_ferr = 0;

  // Reference model state.
  logic        m_wv = 1'b0;
  logic [31:0] m_wd = '0;
  logic        m_ovr = 1'b0;
  logic [7:0]  m_bd = '0;
  logic [7:0]  m_lane[4];
  logic [1:0]  m_cnt = '0;
  logic        rst_seen = 1'b0;
  logic        mon_acc, mon_complete, mon_set_ovr;

  // Observation counters for the directed checks.
  int          bv_count = 0;
  int          ferr_count = 0;
  int          wv_cycles = 0;
  logic [7:0]  last_bd = '0;
  logic [31:0] last_wd = '0;
  logic        mid_busy = 1'b0;

  logic        rand_ready_en = 1'b0;
  logic        ready_val = 1'b1;
  logic [7:0]  rb;
  int          bv0, f0, w0;

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Per-cycle compare against the model, then advance the model for the next edge.
  always @(negedge clk) begin
    if (rst_seen) begin
      check8 ("rst_byte_data", byte_data, 8'h00);
      check1 ("rst_byte_valid", byte_valid, 1'b0);
      check32("rst_word_data", word_data, 32'h0);
      check1 ("rst_word_valid", word_valid, 1'b0);
      check1 ("rst_frame_err", frame_err, 1'b0);
      check1 ("rst_overrun", overrun, 1'b0);
      check1 ("rst_busy", busy, 1'b0);
    end
    if (byte_valid) begin
      bv_count++;
      last_bd = byte_data;
      $display("rx byte %02h", byte_data);
      check1("byte_expected", exp_bytes.size() > 0, 1'b1);
      if (exp_bytes.size() > 0) m_bd = exp_bytes.pop_front();
    end
    if (frame_err) begin
      ferr_count++;
      $display("rx frame error");
      check1("frame_err_expected", pend_ferr > 0, 1'b1);
      if (pend_ferr > 0) pend_ferr--;
    end
    if (word_valid) begin
      wv_cycles++;
      last_wd = word_data;
    end
    check8 ("byte_data", byte_data, m_bd);
    check1 ("word_valid", word_valid, m_wv);
    check32("word_data", word_data, m_wd);
    check1 ("overrun", overrun, m_ovr);

    if (rst) begin
      m_wv  = 1'b0;
      m_wd  = '0;
      m_ovr = 1'b0;
      m_bd  = '0;
      m_cnt = '0;
      exp_bytes.delete();
      pend_ferr = 0;
    end else begin
      mon_acc      = m_wv && word_ready;
      mon_complete = byte_valid && (m_cnt == 2'd3);
      mon_set_ovr  = mon_complete && m_wv && !mon_acc;
      if (mon_acc) $display("word accepted %08h", m_wd);
      if (byte_valid) begin
        m_lane[m_cnt] = m_bd;
        m_cnt = m_cnt + 2'd1;
      end
      if (frame_err) m_cnt = '0;
      if (mon_complete && (!m_wv || mon_acc)) begin
        m_wd = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        m_wv = 1'b1;
      end else if (mon_acc) begin
        m_wv = 1'b0;
      end
      if (mon_set_ovr) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
    end
    rst_seen = rst;
  end

  // word_ready driver: either a fixed level or a random one per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      word_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(BIT_CLKS);
  endtask

  // One 8N1 frame; a zero stop bit leaves the line low for the caller.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) exp_bytes.push_back(b);
    else pend_ferr++;
    $display("tx byte %02h stop=%0b", b, stop);
    drive_bit(1'b0);
    mid_busy = busy;
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin
      idle(1);
      n++;
    end
    check1("busy_idle", busy, 1'b0);
    idle(4);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(5);

    // Single byte 0x55.
    bv0 = bv_count; f0 = ferr_count;
    send_frame(8'h55, 1'b1);
    wait_idle();
    check1 ("t1_busy_mid", mid_busy, 1'b1);
    check32("t1_bv_count", 32'(bv_count - bv0), 32'd1);
    check8 ("t1_byte", last_bd, 8'h55);
    check32("t1_ferr_count", 32'(ferr_count - f0), 32'd0);
    pulse_reset(3);

    // Four bytes back-to-back, consumer always ready.
    w0 = wv_cycles;
    send_frame(8'h78, 1'b1);
    send_frame(8'h56, 1'b1);
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    wait_idle();
    check32("t2_wv_cycles", 32'(wv_cycles - w0), 32'd1);
    check32("t2_word", last_wd, 32'h12345678);
    check1 ("t2_wv_low", word_valid, 1'b0);

    // Consumer stalled for two words: second word is dropped.
    ready_val = 1'b0;
    idle(2);
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b1);
    wait_idle();
    check1 ("t3_overrun", overrun, 1'b1);
    check1 ("t3_wv", word_valid, 1'b1);
    check32("t3_word", word_data, 32'h04030201);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    check1("t3_overrun_clr", overrun, 1'b0);
    ready_val = 1'b1;
    idle(3);
    check1("t3_drained", word_valid, 1'b0);

    // Bad stop bit followed by a held-low line.
    send_frame(8'hEE, 1'b1);
    wait_idle();
    bv0 = bv_count; f0 = ferr_count;
    send_frame(8'hA5, 1'b0);
    idle(5 * BIT_CLKS);
    rx = 1'b1;
    wait_idle();
    check32("t4_ferr_count", 32'(ferr_count - f0), 32'd1);
    check32("t4_bv_count", 32'(bv_count - bv0), 32'd0);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    wait_idle();
    check32("t4_word", last_wd, 32'h44332211);

    // Short low glitch is rejected.
    bv0 = bv_count; f0 = ferr_count;
    rx = 1'b0;
    idle(10);
    check1("t5_busy_glitch", busy, 1'b1);
    idle(20);
    rx = 1'b1;
    idle(200);
    check1 ("t5_busy_after", busy, 1'b0);
    check32("t5_bv_count", 32'(bv_count - bv0), 32'd0);
    check32("t5_ferr_count", 32'(ferr_count - f0), 32'd0);

    // Reset in the middle of the data bits, then a clean byte.
    rx = 1'b0;
    idle(BIT_CLKS);
    rx = 1'b1;
    idle(BIT_CLKS);
    rx = 1'b0;
    idle(BIT_CLKS / 2);
    rst = 1'b1;
    rx = 1'b1;
    idle(20);
    rst = 1'b0;
    idle(20);
    check1("t6_busy_after_rst", busy, 1'b0);
    bv0 = bv_count;
    send_frame(8'hC3, 1'b1);
    wait_idle();
    check32("t6_bv_count", 32'(bv_count - bv0), 32'd1);
    check8 ("t6_byte", last_bd, 8'hC3);

    // Random bytes, random consumer stalls, occasional framing errors and clears.
    rand_ready_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(rb, 1'b0);
        idle($urandom_range(1, 3) * BIT_CLKS);
        rx = 1'b1;
        idle(BIT_CLKS);
      end else begin
        send_frame(rb, 1'b1);
        idle($urandom_range(0, 40));
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
      end
    end
    wait_idle();
    rand_ready_en = 1'b0;
    ready_val = 1'b1;
    idle(5);

    check32("end_bytes_pending", 32'(exp_bytes.size()), 32'd0);
    check32("end_ferr_pending", 32'(pend_ferr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
